// File: rtl/udt_socket_ctrl.sv
// ---------------------------------------------------------------------------
// udt_socket_ctrl
//
// Initiator side of the UDT socket control interface. Turns one-cycle user
// connect/close commands into the level-held Req_Connect / Req_Close request
// handshake toward the socket responder. It then consumes one udt_state word
// to confirm the outcome. It also answers a peer-initiated close
// (Peer_Req_Close -> one-cycle Peer_Res_Close).
//
// Handshake rules:
//   * Req_Connect / Req_Close are levels. Each is held until the matching
//     one-cycle Res_* pulse is sampled, or until the wait times out.
//   * A udt_state word transfers on a rising edge where
//     state_valid & state_ready are both 1. state_ready is only ever high in
//     WAIT_CONN / WAIT_CLOSE. A word offered at any other time stays pending
//     on the bus and is not consumed.
//
// Ports:
//   core_clk, core_rst     clock (rising edge), async active-high reset
//   user_connect           connect command, honoured in IDLE only
//   user_close             close command, honoured in CONNECTED only
//   user_clear             leaves ERROR and clears the sticky error flags
//   Req_Connect/Res_Connect connect request level / responder accept pulse
//   Req_Close/Res_Close    close request level / responder accept pulse
//   Peer_Req_Close         peer close request (level)
//   Peer_Res_Close         one-cycle acknowledge of the peer close
//   state_valid/state_ready/udt_state  incoming udt_state word stream
//   connected              1 while in CONNECTED
//   busy                   1 in any transient state (not IDLE/CONNECTED/ERROR)
//   last_state             last accepted udt_state word (matching or not)
//   err_timeout            sticky: a responder wait ran out
//   err_state              sticky: an accepted word was not the expected code
//   dbg_fsm_state          current FSM state code, for observation only
//
// Every output is a register. Each transition below writes the complete
// output set for its target state. Because of that, the outputs change on
// the same edge as the state.
// ---------------------------------------------------------------------------
module udt_socket_ctrl #(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          CNT_W          = 16,
    parameter logic [31:0] ST_CONNECTED   = 32'h0000_0010,
    parameter logic [31:0] ST_CLOSED      = 32'h0000_1000
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        user_connect,
    input  logic        user_close,
    input  logic        user_clear,
    output logic        Req_Connect,
    input  logic        Res_Connect,
    output logic        Req_Close,
    input  logic        Res_Close,
    input  logic        Peer_Req_Close,
    output logic        Peer_Res_Close,
    input  logic        state_valid,
    output logic        state_ready,
    input  logic [31:0] udt_state,
    output logic        connected,
    output logic        busy,
    output logic [31:0] last_state,
    output logic        err_timeout,
    output logic        err_state,
    output logic [2:0]  dbg_fsm_state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REQ_CONN   = 3'd1,
        WAIT_CONN  = 3'd2,
        CONNECTED  = 3'd3,
        PEER_ACK   = 3'd4,
        REQ_CLOSE  = 3'd5,
        WAIT_CLOSE = 3'd6,
        ERROR      = 3'd7
    } state_t;

    // Last count value of a wait.
    // The counter is 0 in the first cycle of a wait state. Reaching this value
    // therefore means TIMEOUT_CYCLES cycles have been spent in that state.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // A word transfers only when ready is already high.
    // That can only be true inside a wait state.
    logic xfer;
    assign xfer = state_valid & state_ready;

    // Observation-only copy of the FSM state.
    // It is a plain cast of the state register, with no logic of its own.
    assign dbg_fsm_state = state;

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state          <= IDLE;
            cnt            <= '0;
            Req_Connect    <= 1'b0;
            Req_Close      <= 1'b0;
            Peer_Res_Close <= 1'b0;
            state_ready    <= 1'b0;
            connected      <= 1'b0;
            busy           <= 1'b0;
            last_state     <= '0;
            err_timeout    <= 1'b0;
            err_state      <= 1'b0;
        end else begin
            // The peer acknowledge is a pulse.
            // Only the CONNECTED -> PEER_ACK transition raises it.
            Peer_Res_Close <= 1'b0;

            case (state)
                IDLE: begin
                    if (user_connect) begin
                        state       <= REQ_CONN;
                        cnt         <= '0;
                        Req_Connect <= 1'b1;
                        busy        <= 1'b1;
                    end
                end

                REQ_CONN: begin
                    // The awaited event is checked before the timeout.
                    // A Res_Connect in the last cycle therefore still counts.
                    if (Res_Connect) begin
                        state       <= WAIT_CONN;
                        cnt         <= '0;
                        Req_Connect <= 1'b0;
                        state_ready <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state       <= ERROR;
                        Req_Connect <= 1'b0;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_CONN: begin
                    if (xfer) begin
                        last_state  <= udt_state;
                        state_ready <= 1'b0;
                        busy        <= 1'b0;
                        if (udt_state == ST_CONNECTED) begin
                            state     <= CONNECTED;
                            connected <= 1'b1;
                        end else begin
                            state     <= ERROR;
                            err_state <= 1'b1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state       <= ERROR;
                        state_ready <= 1'b0;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                CONNECTED: begin
                    // A peer close takes priority.
                    // A user_close in the same cycle is dropped.
                    if (Peer_Req_Close) begin
                        state          <= PEER_ACK;
                        Peer_Res_Close <= 1'b1;
                        connected      <= 1'b0;
                        busy           <= 1'b1;
                    end else if (user_close) begin
                        state     <= REQ_CLOSE;
                        cnt       <= '0;
                        Req_Close <= 1'b1;
                        connected <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                PEER_ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                REQ_CLOSE: begin
                    if (Res_Close) begin
                        state       <= WAIT_CLOSE;
                        cnt         <= '0;
                        Req_Close   <= 1'b0;
                        state_ready <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state       <= ERROR;
                        Req_Close   <= 1'b0;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_CLOSE: begin
                    if (xfer) begin
                        last_state  <= udt_state;
                        state_ready <= 1'b0;
                        busy        <= 1'b0;
                        if (udt_state == ST_CLOSED) begin
                            state <= IDLE;
                        end else begin
                            state     <= ERROR;
                            err_state <= 1'b1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state       <= ERROR;
                        state_ready <= 1'b0;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ERROR: begin
                    if (user_clear) begin
                        state       <= IDLE;
                        err_timeout <= 1'b0;
                        err_state   <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
